// File: rtl/omi_lane_aligner.sv
// OMI lane block aligner: hunts for sync-header lock, requests gearbox
// slips on bad headers, monitors header quality while locked, and
// re-registers the lane data with one cycle of latency.
module omi_lane_aligner #(
    parameter int PHY_BITS  = 8,
    parameter int LOCK_CNT  = 64,
    parameter int WIN_CNT   = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [1:0]          rx_header,
    input  logic [PHY_BITS-1:0] rx_data,
    output logic                rx_slip,
    output logic                locked,
    output logic                out_valid,
    output logic [1:0]          out_header,
    output logic [PHY_BITS-1:0] out_data,
    output logic                lock_lost,
    output logic [7:0]          slip_cnt
);

    localparam int GW  = $clog2(LOCK_CNT + 1);
    localparam int WNW = $clog2(WIN_CNT + 1);
    localparam int BW  = $clog2(BAD_MAX + 1);
    localparam int WW  = $clog2(SLIP_WAIT + 1);

    localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [WNW-1:0] WIN_LAST  = WNW'(WIN_CNT - 1);
    localparam logic [BW-1:0]  BAD_LAST  = BW'(BAD_MAX - 1);
    localparam logic [WW-1:0]  WAIT_LOAD = WW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   good_cnt, good_cnt_n;
    logic [WNW-1:0]  win_cnt, win_cnt_n;
    logic [BW-1:0]   bad_cnt, bad_cnt_n;
    logic [WW-1:0]   wait_cnt, wait_cnt_n;
    logic [7:0]      slip_cnt_n;
    logic            slip_n;
    logic            lost_n;
    logic            hdr_good;

    logic                vld_p1;
    logic [1:0]          hdr_p1;
    logic [PHY_BITS-1:0] data_p1;

    // Saturating increment for the slip counter: holds at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // A sync header is valid only when its two bits differ (01 or 10).
    assign hdr_good = rx_header[1] ^ rx_header[0];

    // Next-state and next-counter logic for the alignment FSM.
    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        win_cnt_n  = win_cnt;
        bad_cnt_n  = bad_cnt;
        wait_cnt_n = wait_cnt;
        slip_cnt_n = slip_cnt;
        slip_n     = 1'b0;
        lost_n     = 1'b0;
        unique case (state)
            ST_HUNT: begin
                if (rx_valid) begin
                    if (hdr_good) begin
                        if (good_cnt == GOOD_LAST) begin
                            state_n    = ST_LOCKED;
                            good_cnt_n = '0;
                            win_cnt_n  = '0;
                            bad_cnt_n  = '0;
                        end else begin
                            good_cnt_n = good_cnt + 1'b1;
                        end
                    end else begin
                        state_n    = ST_SLIP_WAIT;
                        good_cnt_n = '0;
                        wait_cnt_n = WAIT_LOAD;
                        slip_n     = 1'b1;
                        slip_cnt_n = sat_inc8(slip_cnt);
                    end
                end
            end
            ST_SLIP_WAIT: begin
                // Countdown runs regardless of rx_valid; headers are ignored.
                if (wait_cnt == '0) begin
                    state_n    = ST_HUNT;
                    good_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt - 1'b1;
                end
            end
            ST_LOCKED: begin
                if (rx_valid) begin
                    // Too many bad headers wins over a simultaneous window wrap.
                    if (!hdr_good && (bad_cnt == BAD_LAST)) begin
                        state_n    = ST_SLIP_WAIT;
                        good_cnt_n = '0;
                        win_cnt_n  = '0;
                        bad_cnt_n  = '0;
                        wait_cnt_n = WAIT_LOAD;
                        slip_n     = 1'b1;
                        lost_n     = 1'b1;
                        slip_cnt_n = sat_inc8(slip_cnt);
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt_n = '0;
                        bad_cnt_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + 1'b1;
                        if (!hdr_good) begin
                            bad_cnt_n = bad_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    // State, counters, status pulses and the one-cycle datapath register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HUNT;
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= '0;
            slip_cnt   <= '0;
            rx_slip    <= 1'b0;
            lock_lost  <= 1'b0;
            locked     <= 1'b0;
            vld_p1     <= 1'b0;
            hdr_p1     <= 2'b00;
            data_p1    <= '0;
        end else begin
            state      <= state_n;
            good_cnt   <= good_cnt_n;
            win_cnt    <= win_cnt_n;
            bad_cnt    <= bad_cnt_n;
            wait_cnt   <= wait_cnt_n;
            slip_cnt   <= slip_cnt_n;
            rx_slip    <= slip_n;
            lock_lost  <= lost_n;
            locked     <= (state_n == ST_LOCKED);
            // Stage p1: lane data registered, valid gated by current lock.
            vld_p1     <= rx_valid & locked;
            hdr_p1     <= rx_header;
            data_p1    <= rx_data;
        end
    end

    assign out_valid  = vld_p1;
    assign out_header = hdr_p1;
    assign out_data   = data_p1;

endmodule

// File: tb/tb_omi_lane_aligner.sv
// Testbench for omi_lane_aligner: constant vector table, directed
// sequences for lock/slip/window corners, and randomized traffic checked
// against a cycle-level behavioural model.
module tb_omi_lane_aligner;

    localparam int PB        = 8;
    localparam int LOCK_CNT  = 64;
    localparam int WIN_CNT   = 64;
    localparam int BAD_MAX   = 16;
    localparam int SLIP_WAIT = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [1:0]    rx_header = 2'b00;
    logic [PB-1:0] rx_data = '0;
    logic          rx_slip;
    logic          locked;
    logic          out_valid;
    logic [1:0]    out_header;
    logic [PB-1:0] out_data;
    logic          lock_lost;
    logic [7:0]    slip_cnt;

    always #5 clk = ~clk;

    omi_lane_aligner #(
        .PHY_BITS(PB), .LOCK_CNT(LOCK_CNT), .WIN_CNT(WIN_CNT),
        .BAD_MAX(BAD_MAX), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_header(rx_header),
        .rx_data(rx_data), .rx_slip(rx_slip), .locked(locked),
        .out_valid(out_valid), .out_header(out_header), .out_data(out_data),
        .lock_lost(lock_lost), .slip_cnt(slip_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: lane is either locked or hunting; while hunting,
    // headers are considered only from cycle m_resume onward.
    bit   m_locked = 0;
    int   m_resume = 0;
    int   m_good_run = 0;
    bit   m_win_q[$];
    int   m_slip_cnt = 0;
    int   n = 0;
    logic e_slip = 0, e_lost = 0, e_locked = 0, e_ov = 0;
    logic [1:0]    e_oh = 0;
    logic [PB-1:0] e_od = 0;

    int cyc = 0;
    int last_slip = -1;
    int bad_spacing = 0;
    int slips_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_good(input logic [1:0] h);
        return (h == 2'b01) || (h == 2'b10);
    endfunction

    function automatic int bad_in_win();
        int c = 0;
        foreach (m_win_q[i]) c += m_win_q[i];
        return c;
    endfunction

    task automatic m_slip();
        e_slip = 1;
        m_good_run = 0;
        m_resume = n + SLIP_WAIT + 1;
        if (m_slip_cnt < 255) m_slip_cnt++;
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [1:0] h, input logic [PB-1:0] d);
        if (r) begin
            m_locked = 0; m_resume = 0; m_good_run = 0; m_win_q.delete();
            m_slip_cnt = 0; n = 0;
            e_slip = 0; e_lost = 0; e_locked = 0; e_ov = 0; e_oh = 0; e_od = 0;
            return;
        end
        n++;
        e_ov = v && e_locked;
        e_oh = h;
        e_od = d;
        e_slip = 0;
        e_lost = 0;
        if (!m_locked) begin
            if (v && n >= m_resume) begin
                if (is_good(h)) begin
                    m_good_run++;
                    if (m_good_run == LOCK_CNT) begin
                        m_locked = 1;
                        m_good_run = 0;
                        m_win_q.delete();
                    end
                end else begin
                    m_slip();
                end
            end
        end else if (v) begin
            m_win_q.push_back(!is_good(h));
            if (bad_in_win() == BAD_MAX) begin
                m_locked = 0;
                e_lost = 1;
                m_win_q.delete();
                m_slip();
            end else if (m_win_q.size() == WIN_CNT) begin
                m_win_q.delete();
            end
        end
        e_locked = m_locked;
    endtask

    // One clock: drive inputs, advance model, compare every output.
    task automatic step(input bit r, input bit v, input logic [1:0] h, input logic [PB-1:0] d);
        rst = r; rx_valid = v; rx_header = h; rx_data = d;
        @(posedge clk);
        model_edge(r, v, h, d);
        #1;
        cyc++;
        chk("locked", locked, e_locked);
        chk("out_valid", out_valid, e_ov);
        chk("out_header", out_header, e_oh);
        chk("out_data", out_data, e_od);
        chk("rx_slip", rx_slip, e_slip);
        chk("lock_lost", lock_lost, e_lost);
        chk("slip_cnt", slip_cnt, m_slip_cnt);
        if (r) last_slip = -1;
        if (rx_slip === 1'b1) begin
            slips_seen++;
            if (last_slip >= 0 && (cyc - last_slip) < SLIP_WAIT + 1) bad_spacing++;
            last_slip = cyc;
        end
    endtask

    task automatic good_hdrs(input int cnt);
        for (int i = 0; i < cnt; i++) step(0, 1, (i % 2) ? 2'b10 : 2'b01, 8'($urandom));
    endtask

    typedef struct {
        bit r; bit v; logic [1:0] h; logic [7:0] d;
        logic locked; logic ov; logic [1:0] oh; logic [7:0] od;
        logic slip; logic lost; logic [7:0] sc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int sl;
        int rate;

        // Constant vector table starting from reset.
        tbl[0] = '{1, 1, 2'b01, 8'h5A, 0, 0, 2'b00, 8'h00, 0, 0, 8'd0};
        tbl[1] = '{0, 1, 2'b01, 8'hA5, 0, 0, 2'b01, 8'hA5, 0, 0, 8'd0};
        tbl[2] = '{0, 0, 2'b10, 8'h3C, 0, 0, 2'b10, 8'h3C, 0, 0, 8'd0};
        tbl[3] = '{0, 1, 2'b10, 8'hFF, 0, 0, 2'b10, 8'hFF, 0, 0, 8'd0};
        tbl[4] = '{0, 1, 2'b11, 8'h00, 0, 0, 2'b11, 8'h00, 1, 0, 8'd1};
        tbl[5] = '{0, 1, 2'b00, 8'h11, 0, 0, 2'b00, 8'h11, 0, 0, 8'd1};
        tbl[6] = '{0, 0, 2'b01, 8'h22, 0, 0, 2'b01, 8'h22, 0, 0, 8'd1};
        tbl[7] = '{1, 1, 2'b11, 8'h33, 0, 0, 2'b00, 8'h00, 0, 0, 8'd0};
        tbl[8] = '{0, 1, 2'b00, 8'h44, 0, 0, 2'b00, 8'h44, 1, 0, 8'd1};
        tbl[9] = '{1, 1, 2'b10, 8'h55, 0, 0, 2'b00, 8'h00, 0, 0, 8'd0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].d);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].locked);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_out_header", i), out_header, tbl[i].oh);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
            chk($sformatf("tbl%0d_rx_slip", i), rx_slip, tbl[i].slip);
            chk($sformatf("tbl%0d_lock_lost", i), lock_lost, tbl[i].lost);
            chk($sformatf("tbl%0d_slip_cnt", i), slip_cnt, tbl[i].sc);
        end

        // Clean lock: 64 good headers, lock visible after the 64th.
        step(1, 0, 2'b00, 8'h00);
        sl = slips_seen;
        good_hdrs(63);
        chk("lock_after_63", locked, 0);
        good_hdrs(1);
        chk("lock_after_64", locked, 1);
        chk("lock_no_slip", slips_seen - sl, 0);
        chk("lock_slip_cnt", slip_cnt, 0);

        // Slip in HUNT, 32-cycle hold-off, then a full 64 to lock.
        step(1, 0, 2'b00, 8'h00);
        good_hdrs(10);
        step(0, 1, 2'b11, 8'h77);
        chk("hunt_slip_pulse", rx_slip, 1);
        sl = slips_seen;
        good_hdrs(SLIP_WAIT);
        chk("hunt_slip_once", slips_seen - sl, 0);
        good_hdrs(63);
        chk("relock_after_63", locked, 0);
        good_hdrs(1);
        chk("relock_after_64", locked, 1);
        chk("hunt_slip_cnt", slip_cnt, 1);

        // 15 bad in a window stays locked; fresh window starts clean.
        for (int i = 0; i < 15; i++) step(0, 1, (i % 2) ? 2'b00 : 2'b11, 8'($urandom));
        good_hdrs(WIN_CNT - 15);
        chk("win15_locked", locked, 1);
        step(0, 1, 2'b11, 8'h01);
        chk("fresh_win_bad_locked", locked, 1);
        chk("fresh_win_no_lost", lock_lost, 0);

        // 16 bad in one window: unlock with slip and lock_lost together.
        step(1, 0, 2'b00, 8'h00);
        good_hdrs(LOCK_CNT);
        for (int i = 0; i < 15; i++) step(0, 1, 2'b00, 8'($urandom));
        chk("bad15_locked", locked, 1);
        step(0, 1, 2'b11, 8'h99);
        chk("bad16_lock_lost", lock_lost, 1);
        chk("bad16_rx_slip", rx_slip, 1);
        chk("bad16_locked", locked, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 8'($urandom));
        chk("unlock_out_valid", out_valid, 0);

        // rx_valid toggling while locked; invalid bad headers do not count.
        step(1, 0, 2'b00, 8'h00);
        good_hdrs(LOCK_CNT);
        for (int i = 0; i < 40; i++) begin
            step(0, i % 2 == 0, (i % 2 == 0) ? 2'b01 : 2'b11, 8'($urandom));
            chk("toggle_out_valid", out_valid, (i % 2 == 0) ? 1 : 0);
        end
        chk("toggle_locked", locked, 1);

        // Continuous bad headers: slip counter saturates.
        step(1, 0, 2'b00, 8'h00);
        sl = slips_seen;
        for (int i = 0; i < 300 * (SLIP_WAIT + 1); i++) step(0, 1, 2'b11, 8'($urandom));
        chk("sat_slips_seen", slips_seen - sl, 300);
        chk("sat_slip_cnt", slip_cnt, 255);
        step(0, 1, 2'b11, 8'h00);
        step(0, 1, 2'b11, 8'h00);
        step(1, 1, 2'b11, 8'hEE);
        chk("rst_mid_wait_slip_cnt", slip_cnt, 0);
        chk("rst_mid_wait_rx_slip", rx_slip, 0);
        chk("rst_mid_wait_out_data", out_data, 0);
        chk("rst_mid_wait_out_header", out_header, 0);

        // Randomized traffic against the model.
        for (int b = 0; b < 10; b++) begin
            case (b % 4)
                0: rate = 0;
                1: rate = 500;
                2: rate = 40;
                default: rate = 8;
            endcase
            for (int i = 0; i < 2000; i++) begin
                bit rr, vv;
                logic [1:0] hh;
                rr = ($urandom_range(0, 4999) == 0);
                vv = ($urandom_range(0, 99) < 85);
                if (rate != 0 && $urandom_range(0, rate - 1) == 0)
                    hh = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                else
                    hh = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                step(rr, vv, hh, 8'($urandom));
            end
        end

        chk("slip_spacing", bad_spacing, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
